// File: rtl/mux2_4b_arb_ctrl.sv
// Two-requester weighted round-robin arbiter driving a 4-bit 2:1 mux into a single-entry output buffer.
// Optional transfer statistics counters are enabled with `define MUX2_ARB_STATS_EN.
module mux2_4b_arb_ctrl #(
    parameter int unsigned BURST_MAX = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in0_val,
    output logic       in0_rdy,
    input  logic [3:0] in0_msg,
    input  logic       in1_val,
    output logic       in1_rdy,
    input  logic [3:0] in1_msg,
    output logic       sel,
    output logic       out_val,
    input  logic       out_rdy,
    output logic [3:0] out_msg
`ifdef MUX2_ARB_STATS_EN
    ,
    input  logic       stat_clr,
    output logic [7:0] stat_cnt0,
    output logic [7:0] stat_cnt1
`endif
);

    localparam int unsigned MSG_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    logic             prio_q;
    logic [CNT_W-1:0] cnt_q;

    logic             grant;
    logic             accept_ok;
    logic             contended;
    logic             xfer_in;

    logic             prio_d;
    logic [CNT_W-1:0] cnt_d;
    logic             val_d;
    logic [MSG_W-1:0] msg_d;

    // Grant: a lone requester wins; otherwise the priority holder wins.
    always_comb begin
        contended = in0_val & in1_val;
        if (in0_val & ~in1_val) begin
            grant = 1'b0;
        end else if (in1_val & ~in0_val) begin
            grant = 1'b1;
        end else begin
            grant = prio_q;
        end
        accept_ok = ~out_val | out_rdy;
        sel       = grant;
        in0_rdy   = accept_ok & ~grant;
        in1_rdy   = accept_ok & grant;
        xfer_in   = grant ? (in1_val & in1_rdy) : (in0_val & in0_rdy);
    end

    // Next-state: buffer fill/drain and burst-weighted priority rotation.
    always_comb begin
        prio_d = prio_q;
        cnt_d  = cnt_q;
        val_d  = out_val;
        msg_d  = out_msg;
        if (xfer_in) begin
            val_d = 1'b1;
            msg_d = grant ? in1_msg : in0_msg;
            if (contended) begin
                if (cnt_q == CNT_LAST) begin
                    prio_d = ~prio_q;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else if (out_val & out_rdy) begin
            val_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            out_val <= 1'b0;
            out_msg <= '0;
        end else begin
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            out_val <= val_d;
            out_msg <= msg_d;
        end
    end

`ifdef MUX2_ARB_STATS_EN
    // Saturating per-port accepted-transfer counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else if (stat_clr) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else if (xfer_in) begin
            if (!grant && stat_cnt0 != 8'hFF) begin
                stat_cnt0 <= stat_cnt0 + 8'(1);
            end
            if (grant && stat_cnt1 != 8'hFF) begin
                stat_cnt1 <= stat_cnt1 + 8'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux2_4b_arb_ctrl.sv
// Bench for mux2_4b_arb_ctrl: two instances (BURST_MAX 1 and 3) on shared stimulus, checked
// against a transaction-level model every cycle plus directed literal expectations.
module tb_mux2_4b_arb_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in0_val, in1_val, out_rdy;
    logic [3:0] in0_msg, in1_msg;
    logic [1:0] in0_rdy, in1_rdy, sel, out_val;
    logic [3:0] out_msg [2];
`ifdef MUX2_ARB_STATS_EN
    logic       stat_clr;
    logic [7:0] stat_cnt0 [2];
    logic [7:0] stat_cnt1 [2];
`endif

    int  pass_cnt = 0;
    int  tot_cnt  = 0;
    bit  chk_en   = 1'b0;

    mux2_4b_arb_ctrl #(.BURST_MAX(1)) u_b1 (
        .clk(clk), .rst_n(rst_n),
        .in0_val(in0_val), .in0_rdy(in0_rdy[0]), .in0_msg(in0_msg),
        .in1_val(in1_val), .in1_rdy(in1_rdy[0]), .in1_msg(in1_msg),
        .sel(sel[0]), .out_val(out_val[0]), .out_rdy(out_rdy), .out_msg(out_msg[0])
`ifdef MUX2_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_cnt0(stat_cnt0[0]), .stat_cnt1(stat_cnt1[0])
`endif
    );

    mux2_4b_arb_ctrl #(.BURST_MAX(3)) u_b3 (
        .clk(clk), .rst_n(rst_n),
        .in0_val(in0_val), .in0_rdy(in0_rdy[1]), .in0_msg(in0_msg),
        .in1_val(in1_val), .in1_rdy(in1_rdy[1]), .in1_msg(in1_msg),
        .sel(sel[1]), .out_val(out_val[1]), .out_rdy(out_rdy), .out_msg(out_msg[1])
`ifdef MUX2_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_cnt0(stat_cnt0[1]), .stat_cnt1(stat_cnt1[1])
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    // Model: who owns priority, how many contended wins in the current streak, buffer contents.
    logic       m_prio   [2];
    int         m_streak [2];
    logic       m_val    [2];
    logic [3:0] m_msg    [2];

    function automatic int bmax(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic m_grant(input logic p);
        if (in0_val != in1_val) return in1_val;
        return p;
    endfunction

    function automatic logic m_ok(input int d);
        return !m_val[d] || out_rdy;
    endfunction

    function automatic logic m_take(input int d);
        return m_ok(d) && (m_grant(m_prio[d]) ? in1_val : in0_val);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_prio[d]   <= 1'b0;
                m_streak[d] <= 0;
                m_val[d]    <= 1'b0;
                m_msg[d]    <= 4'h0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_take(d)) begin
                    m_val[d] <= 1'b1;
                    m_msg[d] <= m_grant(m_prio[d]) ? in1_msg : in0_msg;
                    if (in0_val && in1_val) begin
                        if (m_streak[d] + 1 == bmax(d)) begin
                            m_prio[d]   <= ~m_prio[d];
                            m_streak[d] <= 0;
                        end else begin
                            m_streak[d] <= m_streak[d] + 1;
                        end
                    end
                end else if (m_val[d] && out_rdy) begin
                    m_val[d] <= 1'b0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("sel_b%0d", bmax(d)), int'(sel[d]), int'(m_grant(m_prio[d])));
                check($sformatf("in0_rdy_b%0d", bmax(d)), int'(in0_rdy[d]),
                      int'(m_ok(d) && !m_grant(m_prio[d])));
                check($sformatf("in1_rdy_b%0d", bmax(d)), int'(in1_rdy[d]),
                      int'(m_ok(d) && m_grant(m_prio[d])));
                check($sformatf("out_val_b%0d", bmax(d)), int'(out_val[d]), int'(m_val[d]));
                check($sformatf("out_msg_b%0d", bmax(d)), int'(out_msg[d]), int'(m_msg[d]));
            end
        end
    end

    initial begin
        logic [3:0] exp_b1 [8];
        logic [3:0] exp_b3 [8];
        exp_b1 = '{4'h3, 4'hC, 4'h3, 4'hC, 4'h3, 4'hC, 4'h3, 4'hC};
        exp_b3 = '{4'h3, 4'h3, 4'h3, 4'hC, 4'hC, 4'hC, 4'h3, 4'h3};

        // Reset with a pending in0 request.
        rst_n   = 1'b0;
        in0_val = 1'b1; in0_msg = 4'hA;
        in1_val = 1'b0; in1_msg = 4'hC;
        out_rdy = 1'b1;
`ifdef MUX2_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_out_val", int'(out_val), 0);
        check("rst_out_msg_b1", int'(out_msg[0]), 0);
        check("rst_out_msg_b3", int'(out_msg[1]), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("first_out_val", int'(out_val), 3);
        check("first_out_msg", int'(out_msg[0]), 'hA);
        check("first_sel", int'(sel), 0);

        // Continuous contention: BURST_MAX 1 alternates, BURST_MAX 3 takes bursts of three.
        in1_val = 1'b1; in0_msg = 4'h3; in1_msg = 4'hC;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("burst_b1_%0d", i), int'(out_msg[0]), int'(exp_b1[i]));
            check($sformatf("burst_b3_%0d", i), int'(out_msg[1]), int'(exp_b3[i]));
            check($sformatf("toggle_sel_b1_%0d", i), int'(sel[0]), (i % 2 == 0) ? 1 : 0);
        end

        // Backpressure: buffer holds 5 for four cycles, then drains and refills in one edge.
        @(posedge clk); #1;
        in0_msg = 4'h5; in1_val = 1'b0;
        @(posedge clk); #1;
        out_rdy = 1'b0; in0_val = 1'b0; in1_val = 1'b1; in1_msg = 4'h9;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold_msg_%0d", i), int'(out_msg[0]), 5);
            check($sformatf("bp_hold_val_%0d", i), int'(out_val[0]), 1);
            check($sformatf("bp_rdy_%0d", i), int'({in0_rdy[0], in1_rdy[0]}), 0);
        end
        @(posedge clk); #1;
        out_rdy = 1'b1;
        @(negedge clk);
        check("bp_release_in1_rdy", int'(in1_rdy[0]), 1);
        @(negedge clk);
        check("bp_refill_msg", int'(out_msg[0]), 9);
        check("bp_refill_val", int'(out_val[0]), 1);

        // Asynchronous reset mid-cycle clears the full buffer without a clock edge.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_val", int'(out_val), 0);
        check("async_rst_out_msg", int'(out_msg[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Uncontended in1 traffic leaves priority with in0.
        @(posedge clk); #1;
        in1_msg = 4'h1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in1_msg = 4'(i + 2);
            @(negedge clk);
            check($sformatf("solo_in1_msg_%0d", i), int'(out_msg[0]), i + 1);
            check($sformatf("solo_in1_sel_%0d", i), int'(sel[0]), 1);
        end
        @(posedge clk); #1;
        in0_val = 1'b1; in0_msg = 4'hE; in1_msg = 4'h7;
        @(negedge clk);
        check("prio_kept_sel", int'(sel), 0);
        check("prio_kept_in0_rdy", int'(in0_rdy), 3);
        @(negedge clk);
        check("prio_kept_msg_b1", int'(out_msg[0]), 'hE);
        check("prio_kept_msg_b3", int'(out_msg[1]), 'hE);

`ifdef MUX2_ARB_STATS_EN
        // Saturation and clear of the in0 transfer counter.
        @(posedge clk); #1;
        in1_val = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("stat_cnt0_sat", int'(stat_cnt0[0]), 'hFF);
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        check("stat_cnt0_clr", int'(stat_cnt0[0]), 0);
        check("stat_cnt1_clr", int'(stat_cnt1[0]), 0);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
